avalon_upsizer: RTL and testbench

Avalon-ST width upsizer placed directly upstream of `avalon_sampler`. Packs `RATIO` consecutive narrow beats from a producer into one wide beat, flushes partial words at end-of-packet with a lane-empty count, and sustains one narrow beat per cycle into the sampler's input buffering.

---
 rtl/avalon_upsizer_pkg.sv | 18 +
 rtl/avalon_st_if.sv | 23 ++
 rtl/avalon_upsizer_acc.sv | 51 +++++
 rtl/avalon_upsizer.sv | 148 ++++++++++++++
 tb/tb_avalon_upsizer.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avalon_upsizer_pkg.sv
// Shared helpers for the Avalon-ST width converters: lane-index sizing and
// the ratio above which elaboration emits a size warning.
package avalon_pkg;

  // Ratios above this produce a very wide output bus and get a warning.
  localparam int WARN_RATIO = 16;

  // Width of a lane index / lane counter for a given narrow-to-wide ratio.
  function automatic int lane_bits(input int ratio);
    return $clog2(ratio);
  endfunction

  // Index of the last (most significant) lane of a wide word.
  function automatic int last_lane(input int ratio);
    return ratio - 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST point-to-point stream: data with valid/ready handshake and packet
// delimiters.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  startofpacket;
  logic                  endofpacket;

  modport master (
    output data, valid, startofpacket, endofpacket,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket,
    output ready
  );

endinterface

// File: rtl/avalon_upsizer_acc.sv
// Lane accumulator for the upsizer: holds the lower RATIO-1 lanes of the word
// being assembled. One lane is written per accepted narrow beat; a synchronous
// clear empties every lane not being written in the same cycle.
module avalon_upsizer_acc #(
  parameter int RATIO     = 4,
  parameter int W         = 8,
  parameter int LANE_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [LANE_BITS-1:0]   i_lane,
  input  logic [W-1:0]           i_data,
  input  logic                   i_clear,
  output logic [(RATIO-1)*W-1:0] o_acc
);

  logic [RATIO-2:0]        w_lane_en;
  logic [RATIO-2:0][W-1:0] r_acc;

  // Decode the lane index into one write enable per stored lane.
  always_comb begin
    // NOTE: default every output of the comb block before any conditional
    // assignment, otherwise the unassigned paths infer latches.
    w_lane_en = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      w_lane_en[k] = i_wr_en && (int'(i_lane) == k);
    end
  end

  // Lane storage: write the selected lane, clear the rest on request.
  always_ff @(posedge clk) begin
    // NOTE: the lane storage is reset explicitly because a word cut short by
    // reset must not leak stale lanes into the next word; sequential state
    // always uses non-blocking assignments so all lanes update together.
    if (!rst_n) begin
      r_acc <= '0;
    end else begin
      for (int k = 0; k < RATIO - 1; k++) begin
        if (w_lane_en[k]) begin
          r_acc[k] <= i_data;
        end else if (i_clear) begin
          r_acc[k] <= '0;
        end
      end
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/avalon_upsizer.sv
// Avalon-ST width upsizer: packs RATIO narrow beats into one wide beat, flushes
// partial words at end-of-packet with an empty-lane count, and restarts the
// word when a start-of-packet arrives mid-word.
module avalon_upsizer
  import avalon_pkg::*;
#(
  parameter int RATIO            = 4,
  parameter bit SUPPRESS_WARNING = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  avalon_st_if.slave                  msg_in,
  avalon_st_if.master                 msg_out,
  output logic [lane_bits(RATIO)-1:0] out_empty,
  output logic                        err_misaligned
);

  localparam int W  = $bits(msg_in.data);
  localparam int OW = $bits(msg_out.data);
  localparam int LB = lane_bits(RATIO);
  localparam logic [LB-1:0] LAST = LB'(last_lane(RATIO));

  if (RATIO < 2) begin : g_bad_ratio
    $fatal(1, "avalon_upsizer: RATIO must be at least 2, got %0d", RATIO);
  end

  if (OW != RATIO * W) begin : g_bad_width
    $fatal(1, "avalon_upsizer: msg_out width %0d must be RATIO*%0d", OW, W);
  end

  if (RATIO > WARN_RATIO && !SUPPRESS_WARNING) begin : g_big_ratio
    $warning("avalon_upsizer: RATIO %0d gives a very wide output bus", RATIO);
  end

  // Word assembly state.
  logic [LB-1:0]          r_cnt;
  logic                   r_start;
  // Output register.
  logic                   r_out_valid;
  logic [OW-1:0]          r_out_data;
  logic                   r_out_sop;
  logic                   r_out_eop;
  logic [LB-1:0]          r_out_empty;
  logic                   r_err;

  logic                   w_completes_raw;
  logic                   w_accept;
  logic                   w_restart;
  logic [LB-1:0]          w_lane;
  logic                   w_completes;
  logic                   w_load;
  logic                   w_acc_wr;
  logic                   w_acc_clr;
  logic [(RATIO-1)*W-1:0] w_acc;
  logic [(RATIO-1)*W-1:0] w_acc_view;
  logic [OW-1:0]          w_word;
  logic                   w_word_sop;

  // Only a beat that would finish a word needs room in the output register;
  // the decision uses the raw counter so ready never depends on sop.
  assign w_completes_raw = (r_cnt == LAST) || msg_in.endofpacket;
  assign msg_in.ready    = !r_out_valid || msg_out.ready || !w_completes_raw;
  assign w_accept        = msg_in.valid && msg_in.ready;

  // A start-of-packet mid-word abandons the partial word and becomes lane 0.
  assign w_restart   = msg_in.startofpacket && (r_cnt != '0);
  assign w_lane      = w_restart ? '0 : r_cnt;
  assign w_completes = (w_lane == LAST) || msg_in.endofpacket;

  assign w_load    = w_accept && w_completes;
  assign w_acc_wr  = w_accept && !w_completes;
  assign w_acc_clr = w_load || (w_accept && w_restart);

  // Lanes above the current one are already zero in the accumulator, so the
  // word is the stored lanes OR'd with the incoming lane at its position.
  assign w_acc_view = w_restart ? '0 : w_acc;
  assign w_word     = {{W{1'b0}}, w_acc_view}
                    | ({{(OW-W){1'b0}}, msg_in.data} << (int'(w_lane) * W));
  assign w_word_sop = (w_lane == '0) ? msg_in.startofpacket : r_start;

  avalon_upsizer_acc #(
    .RATIO     (RATIO),
    .W         (W),
    .LANE_BITS (LB)
  ) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr_en (w_acc_wr),
    .i_lane  (w_lane),
    .i_data  (msg_in.data),
    .i_clear (w_acc_clr),
    .o_acc   (w_acc)
  );

  // Lane counter and packet-start flag of the word under assembly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_start <= 1'b0;
    end else if (w_accept) begin
      if (w_completes) begin
        r_cnt   <= '0;
        r_start <= 1'b0;
      end else begin
        r_cnt <= w_lane + LB'(1);
        if (w_lane == '0) begin
          r_start <= msg_in.startofpacket;
        end
      end
    end
  end

  // Output register: reload on a completing beat, otherwise drain on ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_empty <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_sop   <= w_word_sop;
      r_out_eop   <= msg_in.endofpacket;
      r_out_empty <= LAST - w_lane;
    end else if (r_out_valid && msg_out.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Misalignment pulse, one cycle after the offending beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && w_restart;
    end
  end

  assign msg_out.valid         = r_out_valid;
  assign msg_out.data          = r_out_data;
  assign msg_out.startofpacket = r_out_sop;
  assign msg_out.endofpacket   = r_out_eop;
  assign out_empty             = (r_out_valid && r_out_eop) ? r_out_empty : '0;
  assign err_misaligned        = r_err;

endmodule

// File: tb/tb_avalon_upsizer.sv
// Bench for avalon_upsizer with RATIO=4, W=8: directed scenarios plus a
// randomized stream compared against a word-packing reference model.
module tb_avalon_upsizer;

  localparam int RATIO = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } wbeat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] out_empty;
  logic       err_misaligned;

  avalon_st_if #(.DATA_WIDTH(8))  u_in  ();
  avalon_st_if #(.DATA_WIDTH(32)) u_out ();

  avalon_upsizer #(.RATIO(RATIO), .SUPPRESS_WARNING(1'b0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .msg_in         (u_in),
    .msg_out        (u_out),
    .out_empty      (out_empty),
    .err_misaligned (err_misaligned)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_timeouts = 0;
  int cyc = 0;

  // Observations.
  wbeat_t got_q[$];
  int     got_cyc[$];
  int     acc_cyc[$];
  int     err_cyc_q[$];
  int     err_cnt = 0;
  int     stall_viol = 0;
  int     empty_viol = 0;

  // Reference model state.
  wbeat_t     exp_q[$];
  logic [7:0] cur_q[$];
  logic       cur_sop = 1'b0;
  int         exp_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, well after the driving negedge settles.
  wbeat_t mon_cur;
  wbeat_t mon_prev;
  logic   mon_prev_stall = 1'b0;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      mon_cur.data  = u_out.data;
      mon_cur.sop   = u_out.startofpacket;
      mon_cur.eop   = u_out.endofpacket;
      mon_cur.empty = out_empty;
      if (u_in.valid && u_in.ready) acc_cyc.push_back(cyc);
      if (err_misaligned) begin
        err_cnt++;
        err_cyc_q.push_back(cyc);
      end
      if (!(u_out.valid && u_out.endofpacket) && out_empty !== 2'd0) empty_viol++;
      if (mon_prev_stall && (u_out.valid !== 1'b1 || mon_cur !== mon_prev)) stall_viol++;
      if (u_out.valid && u_out.ready) begin
        got_q.push_back(mon_cur);
        got_cyc.push_back(cyc);
      end
      mon_prev_stall = u_out.valid && !u_out.ready;
      mon_prev       = mon_cur;
    end else begin
      mon_prev_stall = 1'b0;
    end
  end

  // Reference: collect bytes into a word; a mid-word sop discards the
  // collected bytes; a word closes at RATIO bytes or at eop.
  task automatic model_beat(input logic [7:0] d, input logic s, input logic e);
    if (s && cur_q.size() != 0) begin
      cur_q.delete();
      exp_err++;
    end
    if (cur_q.size() == 0) cur_sop = s;
    cur_q.push_back(d);
    if (cur_q.size() == RATIO || e) begin
      wbeat_t b;
      b.data = 32'h0;
      for (int i = 0; i < cur_q.size(); i++) b.data = b.data | (32'(cur_q[i]) << (8 * i));
      b.sop   = cur_sop;
      b.eop   = e;
      b.empty = e ? 2'(RATIO - cur_q.size()) : 2'd0;
      exp_q.push_back(b);
      cur_q.delete();
    end
  endtask

  task automatic model_reset();
    cur_q.delete();
    cur_sop = 1'b0;
  endtask

  task automatic clear_obs();
    got_q.delete();
    got_cyc.delete();
    acc_cyc.delete();
    err_cyc_q.delete();
    exp_q.delete();
    err_cnt    = 0;
    exp_err    = 0;
    stall_viol = 0;
    empty_viol = 0;
  endtask

  // Present one narrow beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [7:0] d, input logic s, input logic e, output int waits);
    int limit;
    limit = (n_timeouts > 0) ? 2 : 200;
    waits = 0;
    @(negedge clk);
    u_in.valid = 1'b1;
    u_in.data = d;
    u_in.startofpacket = s;
    u_in.endofpacket = e;
    #1;
    while (!u_in.ready && waits < limit) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!u_in.ready) begin
      n_total++;
      n_timeouts++;
      $display("FAIL send_timeout: msg_in.ready got 0 expected 1 for byte %h", d);
    end else begin
      model_beat(d, s, e);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    u_in.valid = 1'b0;
    u_in.startofpacket = 1'b0;
    u_in.endofpacket = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    u_in.valid = 1'b0;
    u_in.data = 8'h0;
    u_in.startofpacket = 1'b0;
    u_in.endofpacket = 1'b0;
    u_out.ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_total++; if (u_out.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", u_out.valid); else n_pass++;
    n_total++; if (u_out.data !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", u_out.data); else n_pass++;
    n_total++; if (u_out.startofpacket !== 1'b0) $display("FAIL reset_sop: got %b expected 0", u_out.startofpacket); else n_pass++;
    n_total++; if (u_out.endofpacket !== 1'b0) $display("FAIL reset_eop: got %b expected 0", u_out.endofpacket); else n_pass++;
    n_total++; if (out_empty !== 2'd0) $display("FAIL reset_empty: got %0d expected 0", out_empty); else n_pass++;
    n_total++; if (err_misaligned !== 1'b0) $display("FAIL reset_err: got %b expected 0", err_misaligned); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_total++; if (u_in.ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", u_in.ready); else n_pass++;
  endtask

  task automatic test_stream();
    int w;
    int wsum;
    clear_obs();
    u_out.ready = 1'b1;
    wsum = 0;
    for (int i = 1; i <= 8; i++) begin
      send_beat(8'(i), 1'b0, 1'b0, w);
      wsum += w;
    end
    idle(3);
    n_total++; if (wsum !== 0) $display("FAIL stream_ready: stalled cycles got %0d expected 0", wsum); else n_pass++;
    n_total++; if (got_q.size() !== 2) $display("FAIL stream_count: got %0d expected 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2 && acc_cyc.size() >= 8) begin
      n_total++; if (got_q[0].data !== 32'h04030201) $display("FAIL stream_word0: got %h expected 04030201", got_q[0].data); else n_pass++;
      n_total++; if (got_q[1].data !== 32'h08070605) $display("FAIL stream_word1: got %h expected 08070605", got_q[1].data); else n_pass++;
      n_total++; if (got_q[0].sop !== 1'b0) $display("FAIL stream_sop: got %b expected 0", got_q[0].sop); else n_pass++;
      n_total++; if (got_cyc[0] !== acc_cyc[3] + 1) $display("FAIL stream_lat0: got cycle %0d expected %0d", got_cyc[0], acc_cyc[3] + 1); else n_pass++;
      n_total++; if (got_cyc[1] !== acc_cyc[7] + 1) $display("FAIL stream_lat1: got cycle %0d expected %0d", got_cyc[1], acc_cyc[7] + 1); else n_pass++;
    end
  endtask

  task automatic test_packet();
    int w;
    clear_obs();
    send_beat(8'hA1, 1'b1, 1'b0, w);
    send_beat(8'hA2, 1'b0, 1'b0, w);
    send_beat(8'hA3, 1'b0, 1'b1, w);
    idle(3);
    n_total++; if (got_q.size() !== 1) $display("FAIL packet_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0].data !== 32'h00A3A2A1) $display("FAIL packet_data: got %h expected 00a3a2a1", got_q[0].data); else n_pass++;
      n_total++; if (got_q[0].sop !== 1'b1) $display("FAIL packet_sop: got %b expected 1", got_q[0].sop); else n_pass++;
      n_total++; if (got_q[0].eop !== 1'b1) $display("FAIL packet_eop: got %b expected 1", got_q[0].eop); else n_pass++;
      n_total++; if (got_q[0].empty !== 2'd1) $display("FAIL packet_empty: got %0d expected 1", got_q[0].empty); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int wv[8];
    int early;
    clear_obs();
    u_out.ready = 1'b0;
    fork
      begin
        repeat (10) @(negedge clk);
        u_out.ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) send_beat(8'(8'h10 + i), 1'b0, 1'b0, wv[i]);
    idle(4);
    early = 0;
    for (int i = 0; i < 7; i++) early += wv[i];
    n_total++; if (early !== 0) $display("FAIL stall_early_ready: stalled cycles got %0d expected 0", early); else n_pass++;
    n_total++; if (wv[7] <= 0) $display("FAIL stall_last_ready: stalled cycles got %0d expected >0", wv[7]); else n_pass++;
    n_total++; if (stall_viol !== 0) $display("FAIL stall_stable: changes got %0d expected 0", stall_viol); else n_pass++;
    n_total++; if (got_q.size() !== 2) $display("FAIL stall_count: got %0d expected 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      n_total++; if (got_q[0].data !== 32'h13121110) $display("FAIL stall_word0: got %h expected 13121110", got_q[0].data); else n_pass++;
      n_total++; if (got_q[1].data !== 32'h17161514) $display("FAIL stall_word1: got %h expected 17161514", got_q[1].data); else n_pass++;
      n_total++; if (got_cyc[1] !== got_cyc[0] + 1) $display("FAIL stall_no_bubble: got cycle %0d expected %0d", got_cyc[1], got_cyc[0] + 1); else n_pass++;
    end
  endtask

  task automatic test_misalign();
    int w;
    clear_obs();
    send_beat(8'h11, 1'b1, 1'b0, w);
    send_beat(8'h22, 1'b0, 1'b0, w);
    send_beat(8'h33, 1'b1, 1'b0, w);
    send_beat(8'h44, 1'b0, 1'b0, w);
    send_beat(8'h55, 1'b0, 1'b0, w);
    send_beat(8'h66, 1'b0, 1'b1, w);
    idle(3);
    n_total++; if (err_cnt !== 1) $display("FAIL misalign_pulses: got %0d expected 1", err_cnt); else n_pass++;
    if (err_cyc_q.size() >= 1 && acc_cyc.size() >= 3) begin
      n_total++; if (err_cyc_q[0] !== acc_cyc[2] + 1) $display("FAIL misalign_timing: got cycle %0d expected %0d", err_cyc_q[0], acc_cyc[2] + 1); else n_pass++;
    end
    n_total++; if (got_q.size() !== 1) $display("FAIL misalign_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0].data !== 32'h66554433) $display("FAIL misalign_data: got %h expected 66554433", got_q[0].data); else n_pass++;
      n_total++; if (got_q[0].sop !== 1'b1) $display("FAIL misalign_sop: got %b expected 1", got_q[0].sop); else n_pass++;
    end
  endtask

  task automatic test_reset_midword();
    int w;
    clear_obs();
    send_beat(8'hAA, 1'b0, 1'b0, w);
    send_beat(8'hBB, 1'b0, 1'b0, w);
    @(negedge clk);
    u_in.valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (u_out.valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", u_out.valid); else n_pass++;
    n_total++; if (u_out.data !== 32'h0) $display("FAIL rstmid_data: got %h expected 00000000", u_out.data); else n_pass++;
    n_total++; if (err_misaligned !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err_misaligned); else n_pass++;
    rst_n = 1'b1;
    send_beat(8'h55, 1'b0, 1'b0, w);
    send_beat(8'h56, 1'b0, 1'b0, w);
    send_beat(8'h57, 1'b0, 1'b0, w);
    send_beat(8'h58, 1'b0, 1'b0, w);
    idle(3);
    n_total++; if (got_q.size() !== 1) $display("FAIL rstmid_count: got %0d expected 1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1) begin
      n_total++; if (got_q[0].data !== 32'h58575655) $display("FAIL rstmid_word: got %h expected 58575655", got_q[0].data); else n_pass++;
    end
    n_total++; if (err_cnt !== 0) $display("FAIL rstmid_no_err: pulses got %0d expected 0", err_cnt); else n_pass++;
  endtask

  task automatic test_single_beat();
    int w;
    int wsum;
    clear_obs();
    wsum = 0;
    send_beat(8'h7E, 1'b1, 1'b1, w); wsum += w;
    send_beat(8'h01, 1'b1, 1'b0, w); wsum += w;
    send_beat(8'h02, 1'b0, 1'b0, w); wsum += w;
    send_beat(8'h03, 1'b0, 1'b0, w); wsum += w;
    send_beat(8'h04, 1'b0, 1'b1, w); wsum += w;
    idle(3);
    n_total++; if (wsum !== 0) $display("FAIL single_ready: stalled cycles got %0d expected 0", wsum); else n_pass++;
    n_total++; if (got_q.size() !== 2) $display("FAIL single_count: got %0d expected 2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2 && acc_cyc.size() >= 5) begin
      n_total++; if (got_q[0].data !== 32'h0000007E) $display("FAIL single_data: got %h expected 0000007e", got_q[0].data); else n_pass++;
      n_total++; if (got_q[0].empty !== 2'd3) $display("FAIL single_empty: got %0d expected 3", got_q[0].empty); else n_pass++;
      n_total++; if ({got_q[0].sop, got_q[0].eop} !== 2'b11) $display("FAIL single_sopeop: got %b expected 11", {got_q[0].sop, got_q[0].eop}); else n_pass++;
      n_total++; if (got_q[1].data !== 32'h04030201) $display("FAIL full_data: got %h expected 04030201", got_q[1].data); else n_pass++;
      n_total++; if ({got_q[1].sop, got_q[1].eop, got_q[1].empty} !== 4'b1100) $display("FAIL full_flags: got %b expected 1100", {got_q[1].sop, got_q[1].eop, got_q[1].empty}); else n_pass++;
      n_total++; if (got_cyc[0] !== acc_cyc[0] + 1) $display("FAIL single_lat: got cycle %0d expected %0d", got_cyc[0], acc_cyc[0] + 1); else n_pass++;
      n_total++; if (got_cyc[1] !== acc_cyc[4] + 1) $display("FAIL full_lat: got cycle %0d expected %0d", got_cyc[1], acc_cyc[4] + 1); else n_pass++;
    end
  endtask

  task automatic test_random();
    int w;
    int n;
    logic rand_done;
    clear_obs();
    model_reset();
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          @(negedge clk);
          u_out.ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      send_beat(8'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0), w);
    end
    send_beat(8'($urandom), 1'b0, 1'b1, w);
    rand_done = 1'b1;
    idle(2);
    u_out.ready = 1'b1;
    repeat (4) @(negedge clk);
    n_total++; if (got_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d expected %0d", got_q.size(), exp_q.size()); else n_pass++;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL random_beat[%0d]: got data %h sop %b eop %b empty %0d expected data %h sop %b eop %b empty %0d",
                 i, got_q[i].data, got_q[i].sop, got_q[i].eop, got_q[i].empty,
                 exp_q[i].data, exp_q[i].sop, exp_q[i].eop, exp_q[i].empty);
      else n_pass++;
    end
    n_total++; if (err_cnt !== exp_err) $display("FAIL random_err: pulses got %0d expected %0d", err_cnt, exp_err); else n_pass++;
    n_total++; if (stall_viol !== 0) $display("FAIL random_stable: changes got %0d expected 0", stall_viol); else n_pass++;
    n_total++; if (empty_viol !== 0) $display("FAIL random_empty_qual: nonzero got %0d expected 0", empty_viol); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_packet();
    test_stall();
    test_misalign();
    test_reset_midword();
    test_single_beat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
